// File: rtl/shadow_round_ctrl.sv
// Shadow round sequencer: owns the permutation state register and the W32 generator.
// Each step runs BAmount round-A (SLWS) cycles, one bundle per cycle, then one round-B
// (DBOX) mixing cycle. The datapaths themselves live outside this block.
module shadow_round_ctrl #(
   parameter int unsigned Nbits   = 128,
   parameter int unsigned BAmount = 4,
   parameter int unsigned NSTEPS  = 6,
   parameter logic [31:0] W_SEED  = 32'h0000_0001
) (
   input  logic                     clk,
   input  logic                     nrst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [BAmount*Nbits-1:0] in_state,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [BAmount*Nbits-1:0] out_state,
   output logic [BAmount*Nbits-1:0] slws_state,
   output logic [31:0]              slws_w32,
   input  logic [BAmount*Nbits-1:0] slws_result,
   output logic [BAmount*Nbits-1:0] dbox_state,
   input  logic [BAmount*Nbits-1:0] dbox_result,
   output logic                     busy
);

   localparam int unsigned SW = BAmount * Nbits;
   // Keep counters at least one bit wide so degenerate parameterisations still elaborate.
   localparam int unsigned BW = (BAmount > 1) ? $clog2(BAmount) : 1;
   localparam int unsigned NW = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
   localparam logic [BW-1:0] BLast = BW'(BAmount - 1);
   localparam logic [NW-1:0] NLast = NW'(NSTEPS - 1);

   typedef enum logic [1:0] {
      StIdle,
      StSlws,
      StDbox,
      StDone
   } state_e;

   state_e          st_q;
   logic [SW-1:0]   state_q;
   logic [31:0]     w_q;
   logic [31:0]     w_next;
   logic [BW-1:0]   bcnt_q;
   logic [NW-1:0]   scnt_q;

   // W32 generator: shift left with a four-tap feedback into bit 0.
   always_comb begin
      w_next = {w_q[30:0], w_q[31] ^ w_q[21] ^ w_q[1] ^ w_q[0]};
   end

   // Sequencer: FSM, state register, W generator and bundle/step counters.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         st_q    <= StIdle;
         state_q <= '0;
         w_q     <= W_SEED;
         bcnt_q  <= '0;
         scnt_q  <= '0;
      end else begin
         case (st_q)
            StIdle: begin
               if (in_valid) begin
                  state_q <= in_state;
                  w_q     <= W_SEED;
                  bcnt_q  <= '0;
                  scnt_q  <= '0;
                  st_q    <= StSlws;
               end
            end
            StSlws: begin
               state_q <= slws_result;
               w_q     <= w_next;
               if (bcnt_q == BLast) begin
                  bcnt_q <= '0;
                  st_q   <= StDbox;
               end else begin
                  bcnt_q <= bcnt_q + 1'b1;
               end
            end
            StDbox: begin
               state_q <= dbox_result;
               if (scnt_q == NLast) begin
                  // Park the step counter at zero so it never sits outside its range.
                  scnt_q <= '0;
                  st_q   <= StDone;
               end else begin
                  scnt_q <= scnt_q + 1'b1;
                  st_q   <= StSlws;
               end
            end
            StDone: begin
               if (out_ready) begin
                  st_q <= StIdle;
               end
            end
            default: st_q <= StIdle;
         endcase
      end
   end

   // Handshake and status decode straight from the state register.
   always_comb begin
      in_ready  = (st_q == StIdle);
      out_valid = (st_q == StDone);
      busy      = (st_q == StSlws) || (st_q == StDbox);
   end

   // The single state register feeds both datapaths and the result port.
   always_comb begin
      slws_state = state_q;
      dbox_state = state_q;
      out_state  = state_q;
      slws_w32   = w_q;
   end

endmodule

// File: tb/tb_shadow_round_ctrl.sv
// Directed bench for shadow_round_ctrl with default parameters. The round-A and round-B
// datapaths are stand-in functions; the golden model replays the full schedule with them.
module tb_shadow_round_ctrl;

   localparam int unsigned Nbits   = 128;
   localparam int unsigned BAmount = 4;
   localparam int unsigned NSTEPS  = 6;
   localparam int unsigned SW      = Nbits * BAmount;
   localparam logic [31:0] WSeed   = 32'h0000_0001;

   logic          clk;
   logic          nrst;
   logic          in_valid;
   logic          in_ready;
   logic [SW-1:0] in_state;
   logic          out_valid;
   logic          out_ready;
   logic [SW-1:0] out_state;
   logic [SW-1:0] slws_state;
   logic [31:0]   slws_w32;
   logic [SW-1:0] slws_result;
   logic [SW-1:0] dbox_state;
   logic [SW-1:0] dbox_result;
   logic          busy;

   int n_cmp;
   int n_err;

   shadow_round_ctrl #(
      .Nbits  (Nbits),
      .BAmount(BAmount),
      .NSTEPS (NSTEPS),
      .W_SEED (WSeed)
   ) dut (
      .clk        (clk),
      .nrst       (nrst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_state   (in_state),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_state  (out_state),
      .slws_state (slws_state),
      .slws_w32   (slws_w32),
      .slws_result(slws_result),
      .dbox_state (dbox_state),
      .dbox_result(dbox_result),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] w_step(input logic [31:0] w);
      return {w[30:0], w[31] ^ w[21] ^ w[1] ^ w[0]};
   endfunction

   // Round A stand-in: process bundle 0, rotate bundles down by one.
   function automatic logic [SW-1:0] slws_f(input logic [SW-1:0] s, input logic [31:0] w);
      logic [Nbits-1:0] b0;
      logic [Nbits-1:0] p;
      b0 = s[Nbits-1:0];
      p  = ({b0[94:0], b0[127:95]} ^ {4{w}}) + {96'h0, w};
      return {p, s[SW-1:Nbits]};
   endfunction

   // Round B stand-in: xor each bundle with its half-swapped neighbour and a constant.
   function automatic logic [SW-1:0] dbox_f(input logic [SW-1:0] s);
      logic [SW-1:0]    r;
      logic [Nbits-1:0] nb;
      for (int i = 0; i < BAmount; i++) begin
         nb = s[((i + 1) % BAmount) * Nbits +: Nbits];
         r[i * Nbits +: Nbits] = s[i * Nbits +: Nbits] ^ {nb[63:0], nb[127:64]} ^ {4{32'h9e37_79b9}};
      end
      return r;
   endfunction

   function automatic logic [SW-1:0] golden(input logic [SW-1:0] d);
      logic [SW-1:0] s;
      logic [31:0]   w;
      s = d;
      w = WSeed;
      for (int st = 0; st < NSTEPS; st++) begin
         for (int b = 0; b < BAmount; b++) begin
            s = slws_f(s, w);
            w = w_step(w);
         end
         s = dbox_f(s);
      end
      return s;
   endfunction

   assign slws_result = slws_f(slws_state, slws_w32);
   assign dbox_result = dbox_f(dbox_state);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept d from IDLE and wait (bounded) for out_valid; lat = -1 if it never comes.
   task automatic run_perm(input logic [SW-1:0] d, input bit wiggle, output int lat);
      in_state = d;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         if (wiggle) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_state  = {16{$urandom}};
         end
         tick();
         lat++;
      end
      if (wiggle) begin
         in_valid  = 1'b0;
         out_ready = 1'b0;
      end
      if (!out_valid) lat = -1;
   endtask

   task automatic test_reset();
      nrst = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      in_state = '0;
      #12;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
      n_cmp++; if (out_state !== '0) begin n_err++; $display("FAIL reset_out_state got %h exp 0", out_state); end
      n_cmp++; if (slws_w32 !== WSeed) begin n_err++; $display("FAIL reset_w32 got %h exp %h", slws_w32, WSeed); end
      @(negedge clk);
      nrst = 1'b1;
      tick();
   endtask

   task automatic test_w_sequence();
      logic [31:0]   w_exp [4];
      logic [SW-1:0] g;
      int            lat;
      w_exp[0] = 32'h0000_0001;
      w_exp[1] = 32'h0000_0003;
      w_exp[2] = 32'h0000_0006;
      w_exp[3] = 32'h0000_000d;
      in_state = '0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (slws_w32 !== w_exp[i] || busy !== 1'b1) begin
            n_err++; $display("FAIL w_slws_%0d got %h busy %b exp %h busy 1", i, slws_w32, busy, w_exp[i]);
         end
         tick();
      end
      n_cmp++;
      if (slws_w32 !== 32'h0000_001b) begin
         n_err++; $display("FAIL w_dbox got %h exp 0000001b", slws_w32);
      end
      lat = 4;
      while (!out_valid && lat < 100) begin
         tick();
         lat++;
      end
      n_cmp++; if (lat !== 30) begin n_err++; $display("FAIL latency_zero got %0d exp 30", lat); end
      g = golden('0);
      n_cmp++; if (out_state !== g) begin n_err++; $display("FAIL result_zero got %h exp %h", out_state, g); end
   endtask

   task automatic test_done_hold();
      logic [SW-1:0] g;
      g = golden('0);
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         n_cmp++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_state !== g) begin
            n_err++;
            $display("FAIL done_hold_%0d got ov %b ir %b st %h exp ov 1 ir 0 st %h", i, out_valid, in_ready, out_state, g);
         end
         tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_err++; $display("FAIL done_release got ir %b ov %b exp ir 1 ov 0", in_ready, out_valid);
      end
   endtask

   task automatic test_mid_reset();
      logic [SW-1:0] d;
      logic [SW-1:0] g;
      int            lat;
      bit            saw_ov;
      d = {16{32'hdead_beef}};
      in_state = d;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      saw_ov = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (out_valid) saw_ov = 1'b1;
      end
      #2;
      nrst = 1'b0;
      #1;
      n_cmp++;
      if (out_state !== '0 || busy !== 1'b0 || out_valid !== 1'b0 || saw_ov) begin
         n_err++; $display("FAIL mid_reset got st %h busy %b ov %b early_ov %b exp st 0 busy 0 ov 0", out_state, busy, out_valid, saw_ov);
      end
      n_cmp++; if (slws_w32 !== WSeed) begin n_err++; $display("FAIL mid_reset_w32 got %h exp %h", slws_w32, WSeed); end
      tick();
      tick();
      @(negedge clk);
      nrst = 1'b1;
      tick();
      d = {8{64'h0123_4567_89ab_cdef}};
      run_perm(d, 1'b0, lat);
      g = golden(d);
      n_cmp++; if (lat !== 30) begin n_err++; $display("FAIL latency_after_reset got %0d exp 30", lat); end
      n_cmp++; if (out_state !== g) begin n_err++; $display("FAIL result_after_reset got %h exp %h", out_state, g); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_toggle();
      logic [SW-1:0] d;
      logic [SW-1:0] g;
      int            lat;
      d = {4{128'h0f1e_2d3c_4b5a_6978_8796_a5b4_c3d2_e1f0}};
      run_perm(d, 1'b1, lat);
      g = golden(d);
      n_cmp++; if (lat !== 30) begin n_err++; $display("FAIL latency_toggle got %0d exp 30", lat); end
      n_cmp++; if (out_state !== g) begin n_err++; $display("FAIL result_toggle got %h exp %h", out_state, g); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL toggle_release got %b exp 1", in_ready); end
   endtask

   task automatic test_back_to_back();
      logic [SW-1:0] d [3];
      logic [SW-1:0] g;
      int            n;
      bit            seen;
      d[0] = {16{32'h1111_2222}};
      d[1] = {16{32'ha5a5_0f0f}};
      d[2] = {16{32'h0000_ffff}};
      in_state  = d[0];
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      for (int k = 0; k < 2; k++) begin
         in_state = d[k + 1];
         g = golden(d[k]);
         n = 0;
         seen = 1'b0;
         while (!in_ready && n < 100) begin
            tick();
            n++;
            if (out_valid) begin
               seen = 1'b1;
               n_cmp++;
               if (out_state !== g) begin
                  n_err++; $display("FAIL b2b_result_%0d got %h exp %h", k, out_state, g);
               end
            end
         end
         tick();
         n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL b2b_out_valid_%0d got 0 exp 1", k); end
         n_cmp++; if (n + 1 !== 32) begin n_err++; $display("FAIL b2b_interval_%0d got %0d exp 32", k, n + 1); end
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_w_sequence();
      test_done_hold();
      test_mid_reset();
      test_toggle();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
